// File: rtl/execute_alu_cc_stage.sv
// Y86-64 execute stage: 64-bit ALU, condition-code register, branch/cmov condition
// evaluation and the E->M pipeline register.
module execute_alu_cc_stage #(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E_valid,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic         M_stall,
  input  logic         M_bubble,
  input  logic         set_cc_en,
  output logic         M_valid,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [3:0] INop   = 4'h1;
  localparam logic [3:0] IRrmov = 4'h2;
  localparam logic [3:0] IIrmov = 4'h3;
  localparam logic [3:0] IRmmov = 4'h4;
  localparam logic [3:0] IMrmov = 4'h5;
  localparam logic [3:0] IOpq   = 4'h6;
  localparam logic [3:0] IJxx   = 4'h7;
  localparam logic [3:0] ICall  = 4'h8;
  localparam logic [3:0] IRet   = 4'h9;
  localparam logic [3:0] IPush  = 4'hA;
  localparam logic [3:0] IPop   = 4'hB;

  localparam logic [W-1:0] StackStep = W'(8);

  logic         valid_q;
  logic [3:0]   icode_q;
  logic         cnd_q;
  logic [W-1:0] vale_q;
  logic [W-1:0] vala_q;
  logic [3:0]   dste_q;
  logic [3:0]   dstm_q;
  logic         zf_q, sf_q, of_q;

  logic [W-1:0] add_res, sub_res, alu_res;
  logic         zf_d, sf_d, of_d;
  logic         cc_we;
  logic         cond, cnd;
  logic [3:0]   dste_sel;

  assign add_res = E_valB + E_valA;
  assign sub_res = E_valB - E_valA;

  always_comb begin
    alu_res = '0;
    case (E_icode)
      IRrmov:         alu_res = E_valA;
      IIrmov:         alu_res = E_valC;
      IRmmov, IMrmov: alu_res = E_valB + E_valC;
      ICall, IPush:   alu_res = E_valB - StackStep;
      IRet, IPop:     alu_res = E_valB + StackStep;
      IOpq: begin
        case (E_ifun)
          4'h0:    alu_res = add_res;
          4'h1:    alu_res = sub_res;
          4'h2:    alu_res = E_valB & E_valA;
          4'h3:    alu_res = E_valB ^ E_valA;
          default: alu_res = '0;
        endcase
      end
      default:        alu_res = '0;
    endcase
  end

  // Flag candidates only matter for OPq, the sole CC writer.
  always_comb begin
    zf_d = (alu_res == '0);
    sf_d = alu_res[W-1];
    of_d = 1'b0;
    case (E_ifun)
      4'h0:    of_d = (E_valA[W-1] == E_valB[W-1]) && (add_res[W-1] != E_valA[W-1]);
      4'h1:    of_d = (E_valB[W-1] != E_valA[W-1]) && (sub_res[W-1] != E_valB[W-1]);
      default: of_d = 1'b0;
    endcase
  end

  assign cc_we = E_valid && (E_icode == IOpq) && set_cc_en && !M_stall && !M_bubble;

  // Condition is judged against the CC held before this instruction's own update.
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf_q ^ of_q) | zf_q;
      4'h2:    cond = sf_q ^ of_q;
      4'h3:    cond = zf_q;
      4'h4:    cond = !zf_q;
      4'h5:    cond = !(sf_q ^ of_q);
      4'h6:    cond = !(sf_q ^ of_q) && !zf_q;
      default: cond = 1'b0;
    endcase
    cnd      = ((E_icode == IRrmov) || (E_icode == IJxx)) ? cond : 1'b1;
    dste_sel = ((E_icode == IRrmov) && !cnd) ? RNONE : E_dstE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_we) begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || M_bubble || (!M_stall && !E_valid)) begin
      valid_q <= 1'b0;
      icode_q <= INop;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else if (!M_stall) begin
      valid_q <= 1'b1;
      icode_q <= E_icode;
      cnd_q   <= cnd;
      vale_q  <= alu_res;
      vala_q  <= E_valA;
      dste_q  <= dste_sel;
      dstm_q  <= E_dstM;
    end
  end

  assign M_valid = valid_q;
  assign M_icode = icode_q;
  assign M_Cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;
  assign cc_zf   = zf_q;
  assign cc_sf   = sf_q;
  assign cc_of   = of_q;

endmodule

// File: tb/tb_execute_alu_cc_stage.sv
// Directed-vector bench for execute_alu_cc_stage with hand-computed expectations.
module tb_execute_alu_cc_stage;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         E_valid = 1'b0;
  logic [3:0]   E_icode = 4'h1;
  logic [3:0]   E_ifun = 4'h0;
  logic [W-1:0] E_valA = '0, E_valB = '0, E_valC = '0;
  logic [3:0]   E_dstE = 4'hF, E_dstM = 4'hF;
  logic         M_stall = 1'b0, M_bubble = 1'b0, set_cc_en = 1'b1;
  logic         M_valid, M_Cnd, cc_zf, cc_sf, cc_of;
  logic [3:0]   M_icode, M_dstE, M_dstM;
  logic [W-1:0] M_valE, M_valA;

  int n_vec = 0;
  int n_err = 0;

  execute_alu_cc_stage #(.W(W), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble), .set_cc_en(set_cc_en),
    .M_valid(M_valid), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction on the falling edge, then sample just after the rising edge.
  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [3:0] de, input logic [3:0] dm);
    @(negedge clk);
    E_valid = v; E_icode = ic; E_ifun = fn;
    E_valA = a; E_valB = b; E_valC = c; E_dstE = de; E_dstM = dm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of);
    check_eq({tag, ".zf"}, {63'd0, cc_zf}, {63'd0, zf});
    check_eq({tag, ".sf"}, {63'd0, cc_sf}, {63'd0, sf});
    check_eq({tag, ".of"}, {63'd0, cc_of}, {63'd0, of});
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, ".valid"}, {63'd0, M_valid}, 64'd0);
    check_eq({tag, ".icode"}, {60'd0, M_icode}, 64'h1);
    check_eq({tag, ".cnd"},   {63'd0, M_Cnd},   64'd0);
    check_eq({tag, ".valE"},  M_valE,           64'd0);
    check_eq({tag, ".valA"},  M_valA,           64'd0);
    check_eq({tag, ".dstE"},  {60'd0, M_dstE},  64'hF);
    check_eq({tag, ".dstM"},  {60'd0, M_dstM},  64'hF);
  endtask

  localparam logic [63:0] MaxPos = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_bubble("reset");
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step(1, 4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 4'hF);
    check_eq("add.valE", M_valE, 64'd12);
    check_eq("add.valid", {63'd0, M_valid}, 64'd1);
    check_eq("add.icode", {60'd0, M_icode}, 64'h6);
    check_eq("add.dstE", {60'd0, M_dstE}, 64'h2);
    check_eq("add.valA", M_valA, 64'd5);
    check_cc("add", 1'b0, 1'b0, 1'b0);

    step(1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
    check_eq("sub.valE", M_valE, 64'd0);
    check_cc("sub", 1'b1, 1'b0, 1'b0);
    step(1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    check_eq("jle.cnd", {63'd0, M_Cnd}, 64'd1);
    step(1, 4'h7, 4'h6, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    check_eq("jg.cnd", {63'd0, M_Cnd}, 64'd0);
    step(1, 4'h7, 4'h7, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    check_eq("j7.cnd", {63'd0, M_Cnd}, 64'd0);

    step(1, 4'h6, 4'h0, MaxPos, MaxPos, 64'd0, 4'h4, 4'hF);
    check_eq("ovf.valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check_cc("ovf", 1'b0, 1'b1, 1'b1);
    step(1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check_eq("jl.cnd", {63'd0, M_Cnd}, 64'd0);
    step(1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check_eq("jge.cnd", {63'd0, M_Cnd}, 64'd1);
    step(1, 4'h6, 4'h3, MaxPos, MaxPos, 64'd0, 4'h4, 4'hF);
    check_eq("xor.valE", M_valE, 64'd0);
    check_cc("xor", 1'b1, 1'b0, 1'b0);

    step(1, 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
    check_eq("cmovne0.cnd", {63'd0, M_Cnd}, 64'd0);
    check_eq("cmovne0.dstE", {60'd0, M_dstE}, 64'hF);
    step(1, 4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 4'h2, 4'hF);
    check_eq("and.valE", M_valE, 64'h30);
    check_cc("and", 1'b0, 1'b0, 1'b0);
    step(1, 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
    check_eq("cmovne1.cnd", {63'd0, M_Cnd}, 64'd1);
    check_eq("cmovne1.dstE", {60'd0, M_dstE}, 64'h3);
    check_eq("cmovne1.valE", M_valE, 64'h55);

    M_stall = 1'b1;
    step(1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h6, 4'hF);
    check_eq("stall.valE", M_valE, 64'h55);
    check_eq("stall.icode", {60'd0, M_icode}, 64'h2);
    check_eq("stall.dstE", {60'd0, M_dstE}, 64'h3);
    check_cc("stall", 1'b0, 1'b0, 1'b0);
    M_bubble = 1'b1;
    step(1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h6, 4'hF);
    check_bubble("bubstall");
    check_cc("bubstall", 1'b0, 1'b0, 1'b0);
    M_stall = 1'b0; M_bubble = 1'b0; set_cc_en = 1'b0;
    step(1, 4'h6, 4'h1, 64'd2, 64'd5, 64'd0, 4'h6, 4'hF);
    check_eq("nocc.valE", M_valE, 64'd3);
    check_cc("nocc", 1'b0, 1'b0, 1'b0);
    set_cc_en = 1'b1;

    step(1, 4'hA, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4, 4'hF);
    check_eq("push.valE", M_valE, 64'hF8);
    step(1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h7);
    check_eq("pop.valE", M_valE, 64'h108);
    check_eq("pop.dstM", {60'd0, M_dstM}, 64'h7);
    step(1, 4'h8, 4'h0, 64'd0, 64'h200, 64'h1234, 4'h4, 4'hF);
    check_eq("call.valE", M_valE, 64'h1F8);
    step(1, 4'h9, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 4'hF);
    check_eq("ret.valE", M_valE, 64'h208);
    step(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 4'h1, 4'hF);
    check_eq("irmov.valE", M_valE, 64'hDEAD);
    step(1, 4'h5, 4'h0, 64'd0, 64'h1000, 64'h18, 4'hF, 4'h2);
    check_eq("mrmov.valE", M_valE, 64'h1018);
    step(1, 4'h4, 4'h0, 64'hAB, 64'h2000, 64'h8, 4'hF, 4'hF);
    check_eq("rmmov.valE", M_valE, 64'h2008);
    check_eq("rmmov.valA", M_valA, 64'hAB);
    step(1, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 4'h1, 4'hF);
    check_eq("opbad.valE", M_valE, 64'd0);
    check_cc("opbad", 1'b1, 1'b0, 1'b0);
    step(1, 4'h2, 4'h0, 64'h77, 64'd0, 64'd0, 4'h5, 4'hF);
    check_eq("rrmov.cnd", {63'd0, M_Cnd}, 64'd1);
    check_eq("rrmov.dstE", {60'd0, M_dstE}, 64'h5);
    step(0, 4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 4'h2);
    check_bubble("invalid");

    rst = 1'b1;
    step(1, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
    check_bubble("rstmid");
    check_cc("rstmid", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
    check_eq("neg.valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check_cc("neg", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
